// File: rtl/div_unit_pkg.sv
// Shared RV32M divide constants and the divider FSM state type.
// Decode and execute use the func3/func7/opcode values here.
package div_unit_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } divState_e;

  function automatic logic isRemOp(input logic [2:0] op);
    return (op == INST_REM) || (op == INST_REMU);
  endfunction

  function automatic logic isSignedOp(input logic [2:0] op);
    return (op == INST_DIV) || (op == INST_REM);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Operands are converted to magnitudes up front and signs are restored on write-back.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] result_o,
  output logic [4:0]        rd_addr_o,
  output logic              reg_wen_o
);

  divState_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] quot_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] divAbs_q;
  logic              isRem_q;
  logic              negQuot_q;
  logic              negRem_q;
  logic [4:0]        rdAddr_q;

  logic              signedOp;
  logic              dividendNeg;
  logic              divisorNeg;
  logic [DATA_W-1:0] dividendAbs;
  logic [DATA_W-1:0] divisorAbs;
  logic              divByZero;
  logic              overflow;
  logic [DATA_W:0]   remShift;
  logic [DATA_W:0]   diff;
  logic              canSub;
  logic [DATA_W-1:0] quot_d;
  logic [DATA_W-1:0] rem_d;
  logic [DATA_W-1:0] result_d;

  // Request decode: magnitudes and the two cases that need no iteration.
  always_comb begin
    signedOp    = isSignedOp(op_i);
    dividendNeg = signedOp & dividend_i[DATA_W-1];
    divisorNeg  = signedOp & divisor_i[DATA_W-1];
    dividendAbs = dividendNeg ? (~dividend_i + 1'b1) : dividend_i;
    divisorAbs  = divisorNeg ? (~divisor_i + 1'b1) : divisor_i;
    divByZero   = (divisor_i == '0);
    overflow    = signedOp && (dividend_i == {1'b1, {(DATA_W-1){1'b0}}})
                  && (divisor_i == '1);
  end

  // One restoring step; the extra MSB keeps the shifted partial remainder exact.
  always_comb begin
    remShift = {rem_q, quot_q[DATA_W-1]};
    diff     = remShift - {1'b0, divAbs_q};
    canSub   = (remShift >= {1'b0, divAbs_q});
    rem_d    = canSub ? diff[DATA_W-1:0] : remShift[DATA_W-1:0];
    quot_d   = {quot_q[DATA_W-2:0], canSub};
    if (isRem_q) begin
      result_d = negRem_q ? (~rem_q + 1'b1) : rem_q;
    end else begin
      result_d = negQuot_q ? (~quot_q + 1'b1) : quot_q;
    end
  end

  assign busy_o = ((state_q == ST_IDLE) && start_i) || (state_q == ST_CALC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      divAbs_q  <= '0;
      isRem_q   <= 1'b0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      rdAddr_q  <= '0;
      ready_o   <= 1'b0;
      reg_wen_o <= 1'b0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else begin
      ready_o   <= 1'b0;
      reg_wen_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && !flush_i) begin
            isRem_q  <= isRemOp(op_i);
            rdAddr_q <= rd_addr_i;
            cnt_q    <= '0;
            divAbs_q <= divisorAbs;
            // Special results are stored pre-signed, so the fix-up is disabled.
            if (divByZero) begin
              quot_q    <= '1;
              rem_q     <= dividend_i;
              negQuot_q <= 1'b0;
              negRem_q  <= 1'b0;
              state_q   <= ST_DONE;
            end else if (overflow) begin
              quot_q    <= {1'b1, {(DATA_W-1){1'b0}}};
              rem_q     <= '0;
              negQuot_q <= 1'b0;
              negRem_q  <= 1'b0;
              state_q   <= ST_DONE;
            end else begin
              quot_q    <= dividendAbs;
              rem_q     <= '0;
              negQuot_q <= dividendNeg ^ divisorNeg;
              negRem_q  <= dividendNeg;
              state_q   <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush_i) begin
            state_q <= ST_IDLE;
          end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          if (!flush_i) begin
            ready_o   <= 1'b1;
            reg_wen_o <= 1'b1;
            result_o  <= result_d;
            rd_addr_o <= rdAddr_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: an arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o),
    .reg_wen_o  (reg_wen_o)
  );

  always #5 clk = ~clk;

  // Reference arithmetic straight from the RV32M rules.
  function automatic logic isSpecial(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == INST_DIV) || (op == INST_REM);
    return (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] modelResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic rem;
    logic sgn;
    rem = (op == INST_REM) || (op == INST_REMU);
    sgn = (op == INST_DIV) || (op == INST_REM);
    if (b == 32'h0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : 32'h8000_0000;
    if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? (a % b) : (a / b);
  endfunction

  // Transaction-level model: one pending op with the edge at which it must write back.
  int          edgeIdx = 0;
  bit          resetSeen = 0;
  bit          pending = 0;
  int          doneAt = 0;
  logic [31:0] pendResult;
  logic [4:0]  pendRd;
  bit          expReady = 0;
  logic [31:0] expResult = '0;
  logic [4:0]  expRd = '0;

  always @(posedge clk) begin
    bit wasPending;
    edgeIdx++;
    expReady = 0;
    if (rst) begin
      pending   = 0;
      expResult = '0;
      expRd     = '0;
      resetSeen = 1;
    end else begin
      wasPending = pending;
      if (pending) begin
        if (flush_i) begin
          pending = 0;
        end else if (edgeIdx == doneAt) begin
          expReady  = 1;
          expResult = pendResult;
          expRd     = pendRd;
          pending   = 0;
        end
      end
      if (!wasPending && start_i && !flush_i) begin
        pending    = 1;
        doneAt     = edgeIdx + (isSpecial(op_i, dividend_i, divisor_i) ? 1 : 33);
        pendResult = modelResult(op_i, dividend_i, divisor_i);
        pendRd     = rd_addr_i;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    bit expBusy;
    if (resetSeen) begin
      expBusy = (!pending && start_i) || (pending && (doneAt > edgeIdx + 1));
      checks++;
      if (busy_o !== expBusy) begin
        errors++;
        $display("[TB] FAIL busy: got %0b expected %0b at edge %0d", busy_o, expBusy, edgeIdx);
      end
      checks++;
      if (ready_o !== expReady || reg_wen_o !== expReady) begin
        errors++;
        $display("[TB] FAIL ready/wen: got %0b/%0b expected %0b at edge %0d", ready_o, reg_wen_o, expReady, edgeIdx);
      end
      checks++;
      if (result_o !== expResult || rd_addr_o !== expRd) begin
        errors++;
        $display("[TB] FAIL result/rd: got %h/%0d expected %h/%0d at edge %0d", result_o, rd_addr_o, expResult, expRd, edgeIdx);
      end
    end
  end

  int issueEdge = 0;

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(posedge clk);
    #1;
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    rd_addr_i  = rd;
    @(posedge clk);
    #1;
    issueEdge = edgeIdx;
    start_i   = 1'b0;
  endtask

  // Waits (bounded) for the write-back pulse; latency is counted in edges from the sampling edge.
  task automatic checkOutput(input string name, input logic [31:0] expVal, input logic [4:0] expRdAddr, input int expLat);
    bit found;
    int lat;
    found = 0;
    while (!found && (edgeIdx - issueEdge) < 60) begin
      @(negedge clk);
      if (ready_o === 1'b1) found = 1;
    end
    lat = edgeIdx - issueEdge;
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL %s timeout: got no ready_o, required one within 60 edges", name);
    end else begin
      if (result_o !== expVal || rd_addr_o !== expRdAddr || reg_wen_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s value: got %h rd %0d wen %0b, required %h rd %0d wen 1",
                 name, result_o, rd_addr_o, reg_wen_o, expVal, expRdAddr);
      end
      checks++;
      if (lat != expLat) begin
        errors++;
        $display("[TB] FAIL %s latency: got %0d, required %0d", name, lat, expLat);
      end
    end
  endtask

  task automatic expectNoReady(input string name, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ready_o === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("[TB] FAIL %s: got %0d ready pulses, required 0", name, pulses);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    start_i    = 1'b0;
    op_i       = 3'b000;
    dividend_i = '0;
    divisor_i  = '0;
    rd_addr_i  = '0;
    flush_i    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || reg_wen_o !== 1'b0 || result_o !== 32'h0 || rd_addr_o !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset state: got busy %0b ready %0b wen %0b result %h rd %0d, required all 0",
               busy_o, ready_o, reg_wen_o, result_o, rd_addr_o);
    end
    #1 rst = 1'b0;

    $display("[TB] basic arithmetic");
    applyStimulus(INST_DIVU, 32'd100, 32'd7, 5'd5);
    checkOutput("divu_100_7", 32'd14, 5'd5, 33);
    applyStimulus(INST_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6);
    checkOutput("div_m7_2", 32'hFFFF_FFFD, 5'd6, 33);
    applyStimulus(INST_REM, 32'hFFFF_FFF9, 32'd2, 5'd7);
    checkOutput("rem_m7_2", 32'hFFFF_FFFF, 5'd7, 33);
    applyStimulus(INST_REMU, 32'hFFFF_FFF9, 32'd2, 5'd8);
    checkOutput("remu_big_2", 32'd1, 5'd8, 33);
    applyStimulus(INST_DIV, 32'd100, 32'hFFFF_FFF9, 5'd10);
    checkOutput("div_100_m7", 32'hFFFF_FFF2, 5'd10, 33);
    applyStimulus(INST_REM, 32'hFFFF_FF9C, 32'd7, 5'd11);
    checkOutput("rem_m100_7", 32'hFFFF_FFFE, 5'd11, 33);
    applyStimulus(INST_DIVU, 32'd1000, 32'd3, 5'd0);
    checkOutput("divu_rd0", 32'd333, 5'd0, 33);

    $display("[TB] special cases");
    applyStimulus(INST_DIV, 32'd5, 32'd0, 5'd9);
    checkOutput("div_by_zero", 32'hFFFF_FFFF, 5'd9, 1);
    applyStimulus(INST_REM, 32'd5, 32'd0, 5'd12);
    checkOutput("rem_by_zero", 32'd5, 5'd12, 1);
    applyStimulus(INST_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    checkOutput("div_overflow", 32'h8000_0000, 5'd13, 1);
    applyStimulus(INST_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
    checkOutput("rem_overflow", 32'h0, 5'd14, 1);

    $display("[TB] flush during calc");
    applyStimulus(INST_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd3);
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    expectNoReady("flush_calc", 40);
    applyStimulus(INST_DIVU, 32'd9, 32'd3, 5'd4);
    checkOutput("divu_after_flush", 32'd3, 5'd4, 33);

    $display("[TB] flush during done");
    applyStimulus(INST_DIV, 32'd5, 32'd0, 5'd15);
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    expectNoReady("flush_done", 5);

    $display("[TB] second start ignored");
    applyStimulus(INST_DIVU, 32'd50, 32'd5, 5'd16);
    repeat (4) @(posedge clk);
    #1;
    start_i    = 1'b1;
    op_i       = INST_DIVU;
    dividend_i = 32'd1;
    divisor_i  = 32'd1;
    rd_addr_i  = 5'd17;
    @(posedge clk);
    #1 start_i = 1'b0;
    checkOutput("first_result_only", 32'd10, 5'd16, 33);
    expectNoReady("no_second_result", 40);

    $display("[TB] reset during calc");
    applyStimulus(INST_DIVU, 32'd77, 32'd7, 5'd18);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || reg_wen_o !== 1'b0 || result_o !== 32'h0 || rd_addr_o !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_in_calc: got busy %0b ready %0b wen %0b result %h rd %0d, required all 0",
               busy_o, ready_o, reg_wen_o, result_o, rd_addr_o);
    end
    #1 rst = 1'b0;
    expectNoReady("no_ready_after_reset", 40);
    applyStimulus(INST_REMU, 32'd1000, 32'd3, 5'd19);
    checkOutput("remu_after_reset", 32'd1, 5'd19, 33);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
